counter_wrap_monitor: RTL and testbench
=======================================

Name: counter_wrap_monitor

Overview:
- Passive checker placed directly downstream of the 4-bit up/down counter.
- Each clock it samples the counter's sync reset, direction and output, and predicts the next value. It flags overflow wraps (15->0), underflow wraps (0->15) and step errors.
- Each event is queued as a timestamped record in a small FIFO with a valid/ready output. Saturating statistics counters run alongside.

Parameters:
- CNT_W, 4: observed counter width; wrap limits are 0 and 2**CNT_W-1.
- DEPTH, 4: event FIFO depth; power of two, >=2.
- TS_W, 16: timestamp width.
- STAT_W, 8: statistics counter width.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cnt_rst  in  1  counter's synchronous reset, as driven to the counter.
- cnt_up  in  1  counter direction; 1 = increment, 0 = decrement.
- cnt_dout  in  CNT_W  counter output.
- clr_stats  in  1  synchronous clear of the statistics counters.
- evt_valid  out  1  FIFO head holds a record.
- evt_ready  in  1  consumer accepts the head record.
- evt_code  out  2  head code: 1=OVF, 2=UNF, 3=ERR.
- evt_value  out  CNT_W  cnt_dout at detection.
- evt_time  out  TS_W  timestamp at detection.
- ovf_cnt  out  STAT_W  overflow count.
- unf_cnt  out  STAT_W  underflow count.
- err_cnt  out  STAT_W  step-error count.
- drop_cnt  out  STAT_W  records lost because the FIFO was full.
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- rst_n low (async): all registers clear immediately.
  - evt_valid=0, fifo_level=0, all stat counters=0, timestamp=0.
  - armed=0, history registers (p_dout, p_up, p_rst) = 0.
  - evt_code/evt_value/evt_time = 0.
- Timestamp: free-running, +1 every edge, wraps modulo 2**TS_W.
- History: every edge, p_dout<=cnt_dout, p_up<=cnt_up, p_rst<=cnt_rst.
- Arming: armed<=1 at the first edge sampling cnt_rst=1. It clears only on rst_n. No checks run while armed=0, so pre-reset X/garbage on cnt_dout is never flagged.
- Check at edge k, only when armed=1 before that edge:
  - exp = p_rst ? 0 : p_up ? p_dout+1 : p_dout-1, computed mod 2**CNT_W.
  - cnt_dout != exp -> ERR. ERR has priority over wrap codes.
  - else !p_rst & p_up & p_dout==max -> OVF.
  - else !p_rst & !p_up & p_dout==0 -> UNF.
  - else no event.
- After an ERR, the next check uses the erroneous value as history; there is no resynchronisation.
- Push:
  - A detected event is written at edge k with code, value=cnt_dout, time=current timestamp.
  - evt_valid rises the cycle after edge k (1-cycle latency).
- Pop: occurs on an edge with evt_valid & evt_ready. Output is FWFT and order is FIFO.
- Full boundary:
  - Full, push without pop: record dropped; drop_cnt increments.
  - Full, push with pop: both occur; level stays DEPTH; no drop.
  - Empty: evt_ready is ignored and the level never goes negative.
- Stats:
  - Increment on detection, whether or not the record is dropped.
  - Saturate at 2**STAT_W-1.
  - clr_stats zeroes all four at the edge and wins over a same-edge increment.
  - clr_stats does not touch the FIFO, the timestamp or armed.
- rst_n mid-operation: queued records are discarded. The block re-arms only after cnt_rst=1 is sampled again.

Decomposition:
- Package counter_mon_pkg holds:
  - evt_code_e enum: EVT_NONE=0, EVT_OVF=1, EVT_UNF=2, EVT_ERR=3.
  - evt_rec_t packed struct {code, value, time}, parameterised via package localparams CNT_W=4 and TS_W=16.
- One sub-module: evt_fifo.
  - Synchronous FWFT FIFO of evt_rec_t with async active-low reset.
  - Ports: push, pop, full, empty, level.
  - Simultaneous push/pop at full is supported.
- Top holds history, arming, classifier, timestamp and stats.

Test Plan:
1. Arm and overflow: cnt_rst=1 for 1 cycle, then cnt_up=1 for 16 cycles (dout 0..15,0) -> one OVF, value=0; ovf_cnt=1; others 0.
2. Underflow: cnt_rst=1, then cnt_up=0 (dout 0->15) -> one UNF, value=15; unf_cnt=1.
3. Step error: counting up, force cnt_dout=5 when exp=3 -> ERR, value=5; err_cnt=1. The next sample 6 produces no event.
4. Backpressure: evt_ready=0, 6 events with DEPTH=4 -> fifo_level=4, drop_cnt=2. Then evt_ready=1 drains 4 records in order with increasing evt_time. A full-FIFO push plus pop in the same cycle leaves level=4 and drop_cnt unchanged.
5. Stats: clr_stats asserted on the same edge as an OVF detection -> ovf_cnt=0, record still queued. Forcing 300 errors with STAT_W=8 -> err_cnt=255.
6. Async reset: rst_n low mid-cycle with 3 queued records -> evt_valid=0 and level=0 without a clock edge. Garbage cnt_dout before the next cnt_rst=1 produces no events.

Source files
------------

// File: rtl/counter_mon_pkg.sv
// Shared types for the counter wrap monitor: event codes and the queued event record.
package counter_mon_pkg;

    localparam int CNT_W = 4;
    localparam int TS_W  = 16;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_OVF  = 2'd1,
        EVT_UNF  = 2'd2,
        EVT_ERR  = 2'd3
    } evt_code_e;

    typedef struct packed {
        evt_code_e        code;
        logic [CNT_W-1:0] value;
        logic [TS_W-1:0]  ts;
    } evt_rec_t;

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through FIFO of event records; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module evt_fifo
    import counter_mon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  evt_rec_t                 din,
    input  logic                     pop,
    output evt_rec_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    evt_rec_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_pop;
    logic            do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign level   = count;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Head reads as zero when empty so the outputs are clean after reset.
    always_comb begin
        dout = '0;
        if (!empty) dout = mem[rd_ptr];
    end

endmodule

// File: rtl/counter_wrap_monitor.sv
// Passive checker for a wrapping up/down counter: predicts each sample from the
// previous one, queues OVF/UNF/ERR records and keeps saturating statistics.
module counter_wrap_monitor #(
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 16,
    parameter int STAT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cnt_rst,
    input  logic                     cnt_up,
    input  logic [CNT_W-1:0]         cnt_dout,
    input  logic                     clr_stats,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [1:0]               evt_code,
    output logic [CNT_W-1:0]         evt_value,
    output logic [TS_W-1:0]          evt_time,
    output logic [STAT_W-1:0]        ovf_cnt,
    output logic [STAT_W-1:0]        unf_cnt,
    output logic [STAT_W-1:0]        err_cnt,
    output logic [STAT_W-1:0]        drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    import counter_mon_pkg::*;

    logic [TS_W-1:0]   ts;
    logic [CNT_W-1:0]  p_dout;
    logic              p_up;
    logic              p_rst;
    logic              armed;
    logic [CNT_W-1:0]  exp_dout;
    evt_code_e         det_code;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;
    evt_rec_t          rec_in;
    evt_rec_t          rec_out;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts     <= '0;
            p_dout <= '0;
            p_up   <= 1'b0;
            p_rst  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            ts     <= ts + 1'b1;
            p_dout <= cnt_dout;
            p_up   <= cnt_up;
            p_rst  <= cnt_rst;
            armed  <= armed | cnt_rst;
        end
    end

    // A step mismatch outranks a wrap; after an error the bad value becomes history.
    always_comb begin
        exp_dout = p_rst ? '0 : (p_up ? p_dout + 1'b1 : p_dout - 1'b1);
        det_code = EVT_NONE;
        if (armed) begin
            if (cnt_dout != exp_dout)             det_code = EVT_ERR;
            else if (!p_rst && p_up && (p_dout == '1)) det_code = EVT_OVF;
            else if (!p_rst && !p_up && (p_dout == '0)) det_code = EVT_UNF;
        end
    end

    // Event port handshake: evt_valid means the head record is stable; it is
    // consumed on any edge where evt_valid && evt_ready, and evt_ready is
    // ignored while evt_valid is low.
    assign push = (det_code != EVT_NONE);
    assign pop  = evt_valid && evt_ready;
    assign drop = push && full && !pop;

    always_comb begin
        rec_in       = '0;
        rec_in.code  = det_code;
        rec_in.value = cnt_dout;
        rec_in.ts    = ts;
    end

    evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (rec_in),
        .pop   (pop),
        .dout  (rec_out),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign evt_valid = !empty;
    assign evt_code  = rec_out.code;
    assign evt_value = rec_out.value;
    assign evt_time  = rec_out.ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt  <= '0;
            unf_cnt  <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else if (clr_stats) begin
            ovf_cnt  <= '0;
            unf_cnt  <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            ovf_cnt  <= sat_inc(ovf_cnt,  det_code == EVT_OVF);
            unf_cnt  <= sat_inc(unf_cnt,  det_code == EVT_UNF);
            err_cnt  <= sat_inc(err_cnt,  det_code == EVT_ERR);
            drop_cnt <= sat_inc(drop_cnt, drop);
        end
    end

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Directed bench for counter_wrap_monitor: expected records go into a queue that
// a negedge monitor pops and compares whenever a record is consumed.
module tb_counter_wrap_monitor;

    localparam int CNT_W  = 4;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 16;
    localparam int STAT_W = 8;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int REC_W  = 2 + CNT_W + TS_W;

    localparam logic [1:0] C_OVF = 2'd1;
    localparam logic [1:0] C_UNF = 2'd2;
    localparam logic [1:0] C_ERR = 2'd3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cnt_rst;
    logic              cnt_up;
    logic [CNT_W-1:0]  cnt_dout;
    logic              clr_stats;
    logic              evt_valid;
    logic              evt_ready;
    logic [1:0]        evt_code;
    logic [CNT_W-1:0]  evt_value;
    logic [TS_W-1:0]   evt_time;
    logic [STAT_W-1:0] ovf_cnt;
    logic [STAT_W-1:0] unf_cnt;
    logic [STAT_W-1:0] err_cnt;
    logic [STAT_W-1:0] drop_cnt;
    logic [LW-1:0]     fifo_level;

    logic [REC_W-1:0]  exp_q[$];
    logic [REC_W-1:0]  exp_rec;
    int                n_vec = 0;
    int                n_err = 0;
    int                cyc   = 0;
    logic [CNT_W-1:0]  d     = '0;

    counter_wrap_monitor #(
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_rst    (cnt_rst),
        .cnt_up     (cnt_up),
        .cnt_dout   (cnt_dout),
        .clr_stats  (clr_stats),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_value  (evt_value),
        .evt_time   (evt_time),
        .ovf_cnt    (ovf_cnt),
        .unf_cnt    (unf_cnt),
        .err_cnt    (err_cnt),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Scoreboard monitor: a record is consumed on the next edge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL evt_rec: got unexpected code=%0d value=%0d time=%0d, want no record",
                         evt_code, evt_value, evt_time);
            end else begin
                exp_rec = exp_q.pop_front();
                if ({evt_code, evt_value, evt_time} !== exp_rec) begin
                    n_err++;
                    $display("FAIL evt_rec: got code=%0d value=%0d time=%0d, want code=%0d value=%0d time=%0d",
                             evt_code, evt_value, evt_time,
                             exp_rec[REC_W-1 -: 2], exp_rec[TS_W +: CNT_W], exp_rec[TS_W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Driver tasks: inputs change 1ns after a rising edge, one edge per call.
    task automatic drive(input logic r, input logic u, input logic [CNT_W-1:0] v);
        cnt_rst  = r;
        cnt_up   = u;
        cnt_dout = v;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick(input logic r, input logic u);
        drive(r, u, d);
        d = r ? '0 : (u ? d + 1'b1 : d - 1'b1);
    endtask

    task automatic expect_evt(input logic [1:0] c, input logic [CNT_W-1:0] v);
        exp_q.push_back({c, v, cyc[TS_W-1:0]});
    endtask

    initial begin
        rst_n     = 1'b0;
        cnt_rst   = 1'b0;
        cnt_up    = 1'b0;
        cnt_dout  = '0;
        clr_stats = 1'b0;
        evt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        // Reset state
        check("rst_valid", evt_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_stats", {ovf_cnt, unf_cnt, err_cnt, drop_cnt}, 0);
        check("rst_head", {evt_code, evt_value, evt_time}, 0);

        // 1: arm, count 0..15, wrap to 0 -> OVF value 0
        tick(1'b1, 1'b1);
        repeat (16) tick(1'b0, 1'b1);
        check("no_evt_before_wrap", fifo_level, 0);
        expect_evt(C_OVF, 4'd0);
        tick(1'b1, 1'b1);
        check("ovf_valid_latency", evt_valid, 1);
        tick(1'b1, 1'b1);
        check("ovf_cnt_1", ovf_cnt, 1);
        check("unf_err_0", {unf_cnt, err_cnt}, 0);

        // 2: down from 0 -> UNF value 15
        tick(1'b0, 1'b0);
        expect_evt(C_UNF, 4'd15);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("unf_cnt_1", unf_cnt, 1);

        // 3: step error 5 where 3 expected, then 6 is clean
        repeat (3) tick(1'b0, 1'b1);
        expect_evt(C_ERR, 4'd5);
        drive(1'b0, 1'b1, 4'd5);
        d = 4'd6;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check("err_cnt_1", err_cnt, 1);
        tick(1'b1, 1'b1);
        check("err_no_resync_evt", fifo_level, 0);

        // 4: backpressure, 6 errors into a 4-deep FIFO
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < DEPTH) expect_evt(C_ERR, 4'd9);
            drive(1'b0, 1'b1, 4'd9);
        end
        check("full_level", fifo_level, 4);
        check("drop_cnt_2", drop_cnt, 2);
        check("err_cnt_7", err_cnt, 7);
        evt_ready = 1'b1;
        expect_evt(C_ERR, 4'd9);
        drive(1'b0, 1'b1, 4'd9);
        check("full_pushpop_level", fifo_level, 4);
        check("full_pushpop_drop", drop_cnt, 2);
        d = 4'd10;
        tick(1'b1, 1'b1);
        repeat (5) tick(1'b1, 1'b1);
        check("drained_level", fifo_level, 0);

        // 5: clr_stats on the OVF edge
        repeat (16) tick(1'b0, 1'b1);
        clr_stats = 1'b1;
        expect_evt(C_OVF, 4'd0);
        tick(1'b1, 1'b1);
        clr_stats = 1'b0;
        check("clr_ovf_cnt", ovf_cnt, 0);
        check("clr_other_stats", {unf_cnt, err_cnt, drop_cnt}, 0);
        check("clr_rec_kept", {evt_valid, evt_code}, {1'b1, C_OVF});
        repeat (3) tick(1'b1, 1'b1);
        evt_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i < DEPTH) expect_evt(C_ERR, 4'd9);
            drive(1'b0, 1'b1, 4'd9);
        end
        check("err_cnt_sat", err_cnt, 255);
        check("drop_cnt_sat", drop_cnt, 255);
        check("ovf_still_0", ovf_cnt, 0);

        // 6: async reset with records queued, no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", evt_valid, 0);
        check("async_level", fifo_level, 0);
        check("async_stats", {err_cnt, drop_cnt}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        check("garbage_level", fifo_level, 0);
        check("garbage_stats", {ovf_cnt, unf_cnt, err_cnt, drop_cnt}, 0);
        evt_ready = 1'b1;
        tick(1'b1, 1'b1);
        expect_evt(C_ERR, 4'd12);
        drive(1'b0, 1'b1, 4'd12);
        d = 4'd13;
        tick(1'b1, 1'b1);
        repeat (4) tick(1'b1, 1'b1);
        check("rearm_err_cnt", err_cnt, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
